ps2_frame_rx: RTL and testbench

PS/2 device-to-host frame receiver for the keyboard/mouse path. Synchronizes and de-glitches the raw `ps2c`/`ps2d` lines, deserializes the 11-bit frame, checks odd parity and stop bit, and emits one `rx_done_tick` per frame with the scan byte on `dout`. It sits directly upstream of the scan-code monitor and formatter logic, which consume `dout` on `rx_done_tick`. A watchdog recovers from truncated frames.

---
 rtl/ps2_frame_rx.sv | 98 +++++++++
 tb/tb_ps2_frame_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes, de-glitches and deserializes PS/2 device-to-host frames with parity/stop checks and a watchdog.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;
  state_t state, state_n;
  logic c_s1, c_s2, d_s1, d_s2, f_val, f_next, fall_edge;
  logic [FILTER_LEN-1:0] filt;
  logic [3:0] n, n_n;
  logic [9:0] b, b_n;
  logic [WW-1:0] wd, wd_n;
  logic [7:0] dout_n;
  logic pe_n, fe_n, done_n, to_n;
  assign f_next = &filt ? 1'b1 : ~|filt ? 1'b0 : f_val;
  assign fall_edge = f_val & ~f_next;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {c_s1, c_s2, d_s1, d_s2, f_val} <= '1;
      filt <= '1;
      state <= IDLE;
      n <= '0;
      b <= '0;
      wd <= '0;
      dout <= '0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      rx_done_tick <= 1'b0;
      timeout_tick <= 1'b0;
    end else begin
      {c_s2, c_s1} <= {c_s1, ps2c};
      {d_s2, d_s1} <= {d_s1, ps2d};
      filt <= {filt[FILTER_LEN-2:0], c_s2};
      f_val <= f_next;
      state <= state_n;
      n <= n_n;
      b <= b_n;
      wd <= wd_n;
      dout <= dout_n;
      parity_err <= pe_n;
      frame_err <= fe_n;
      rx_done_tick <= done_n;
      timeout_tick <= to_n;
    end
  end
  // Watchdog and shifter only advance in DPS; an edge always beats the terminal count.
  always_comb begin
    state_n = state;
    n_n = n;
    b_n = b;
    wd_n = wd;
    dout_n = dout;
    pe_n = parity_err;
    fe_n = frame_err;
    done_n = 1'b0;
    to_n = 1'b0;
    case (state)
      IDLE: if (fall_edge && rx_en && !d_s2) begin
        state_n = DPS;
        n_n = 4'd9;
        wd_n = '0;
      end
      DPS: if (fall_edge) begin
        b_n = {d_s2, b[9:1]};
        wd_n = '0;
        state_n = (n == 4'd0) ? LOAD : DPS;
        n_n = (n == 4'd0) ? n : n - 4'd1;
      end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
        state_n = IDLE;
        to_n = 1'b1;
        wd_n = '0;
        b_n = '0;
      end else begin
        wd_n = wd + WW'(1);
      end
      LOAD: begin
        state_n = IDLE;
        dout_n = b[7:0];
        pe_n = ~^b[8:0];
        fe_n = ~b[9];
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed scenario tests for ps2_frame_rx with bench-built PS/2 frames.
module tb_ps2_frame_rx;
  logic clk = 0, reset = 0, rx_en = 1, ps2d = 1, ps2c = 1;
  logic rx_done_tick, parity_err, frame_err, timeout_tick;
  logic [7:0] dout;
  int tests = 0, fails = 0;
  int cyc = 0, fall_cyc = 0, done_cnt = 0, to_cnt = 0, done_cyc = 0, to_cyc = 0;

  ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .ps2d(ps2d), .ps2c(ps2c),
    .rx_done_tick(rx_done_tick), .dout(dout), .parity_err(parity_err),
    .frame_err(frame_err), .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_done_tick) begin done_cnt++; done_cyc = cyc; end
    if (timeout_tick) begin to_cnt++; to_cyc = cyc; end
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // glitch=1 inserts a 3-cycle low pulse early in the high phase before this bit
  task automatic send_bit(input logic v, input logic glitch);
    if (glitch) begin
      wait_cyc(5); ps2c = 0; wait_cyc(3); ps2c = 1; wait_cyc(12);
    end else wait_cyc(20);
    ps2d = v;
    wait_cyc(20);
    ps2c = 0;
    fall_cyc = cyc;
    wait_cyc(40);
    ps2c = 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nbits, input int gbit, input logic drop_en);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i], i == gbit);
      if (drop_en && i == 0) rx_en = 0;
    end
    wait_cyc(20);
  endtask

  task automatic chk_out(input string name, input logic [7:0] ed, input logic ep, input logic ef);
    tests++;
    if (dout !== ed || parity_err !== ep || frame_err !== ef) begin
      fails++;
      $display("FAIL %s: got dout=%h pe=%b fe=%b, expected dout=%h pe=%b fe=%b",
               name, dout, parity_err, frame_err, ed, ep, ef);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({rx_done_tick, timeout_tick, dout, parity_err, frame_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_values: got done=%b to=%b dout=%h pe=%b fe=%b",
               rx_done_tick, timeout_tick, dout, parity_err, frame_err);
    end
    wait_cyc(3);
    reset = 1;
    wait_cyc(20);
  endtask

  task automatic test_clean;
    int d0;
    d0 = done_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 0);
    chk_int("clean_tick_count", done_cnt - d0, 1, 1);
    chk_out("clean_1c", 8'h1C, 1'b0, 1'b0);
    chk_int("clean_latency", done_cyc - fall_cyc, 11, 13);
  endtask

  task automatic test_errors_back_to_back;
    int d0;
    d0 = done_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1, 0);
    chk_out("parity_err_1c", 8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0, 11, -1, 0);
    chk_out("frame_err_f0", 8'hF0, 1'b0, 1'b1);
    chk_int("b2b_tick_count", done_cnt - d0, 2, 2);
  endtask

  task automatic test_watchdog;
    int d0, t0;
    d0 = done_cnt;
    t0 = to_cnt;
    send_frame(8'h5A, 1'b1, 1'b1, 5, -1, 0);
    wait_cyc(280);
    chk_int("wd_timeout_count", to_cnt - t0, 1, 1);
    chk_int("wd_timeout_latency", to_cyc - fall_cyc, 209, 213);
    chk_int("wd_no_done", done_cnt - d0, 0, 0);
    chk_out("wd_outputs_held", 8'hF0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, 0);
    chk_out("wd_recover_5a", 8'h5A, 1'b0, 1'b0);
    chk_int("wd_recover_tick", done_cnt - d0, 1, 1);
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    ps2c = 0; wait_cyc(3); ps2c = 1; wait_cyc(40);
    send_frame(8'h29, 1'b0, 1'b1, 11, 5, 0);
    chk_out("glitch_29", 8'h29, 1'b0, 1'b0);
    chk_int("glitch_tick_count", done_cnt - d0, 1, 1);
  endtask

  task automatic test_rx_en;
    int d0;
    d0 = done_cnt;
    rx_en = 0;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 0);
    chk_int("rx_en_off_no_tick", done_cnt - d0, 0, 0);
    chk_out("rx_en_off_held", 8'h29, 1'b0, 1'b0);
    rx_en = 1;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1);
    chk_int("rx_en_drop_tick", done_cnt - d0, 1, 1);
    chk_out("rx_en_drop_1c", 8'h1C, 1'b0, 1'b0);
    rx_en = 1;
  endtask

  task automatic test_reset_mid_frame;
    int d0;
    send_frame(8'h76, 1'b0, 1'b1, 5, -1, 0);
    #2 reset = 0;
    #1 chk_out("mid_reset_outputs", 8'h00, 1'b0, 1'b0);
    wait_cyc(3);
    reset = 1;
    wait_cyc(20);
    d0 = done_cnt;
    send_frame(8'h76, 1'b0, 1'b1, 11, -1, 0);
    chk_out("after_reset_76", 8'h76, 1'b0, 1'b0);
    chk_int("after_reset_tick", done_cnt - d0, 1, 1);
  endtask

  initial begin
    test_reset;
    test_clean;
    test_errors_back_to_back;
    test_watchdog;
    test_glitch;
    test_rx_en;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
